// File: rtl/ps2_pkg.sv
// Shared constants, byte-FSM state type and sequence helpers for the PS/2 key receiver.
package ps2_pkg;

    localparam logic [7:0]  PS2_E0          = 8'hE0;
    localparam logic [7:0]  PS2_E1          = 8'hE1;
    localparam logic [7:0]  PS2_F0          = 8'hF0;
    localparam logic [7:0]  PS2_FAKE_LSHIFT = 8'h12;
    localparam logic [7:0]  PS2_FAKE_NUMLK  = 8'h59;
    localparam int unsigned PS2_FRAME_BITS  = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    // Byte-lane mask keeping the newest n bytes of a 64-bit sequence word.
    function automatic logic [63:0] seq_keep_mask(input logic [3:0] n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) m[i*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 frame receiver: synchronises and filters the pins, then shifts in one byte per frame.
module ps2_byte_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned BIT_TIMEOUT = 12000
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_err
);

    localparam int unsigned FW        = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW        = $clog2(BIT_TIMEOUT + 1);
    localparam int unsigned DATA_BITS = PS2_FRAME_BITS - 3;
    localparam int unsigned CW        = $clog2(DATA_BITS);

    logic [1:0]    r_clk_sync, r_data_sync;
    logic          r_clk_filt, r_data_filt, r_clk_prev;
    logic [FW-1:0] r_clk_cnt, r_data_cnt;
    ps2_state_e    r_state, w_state_d;
    logic [7:0]    r_shift, w_shift_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic          r_par, w_par_d;
    logic [TW-1:0] r_timer, w_timer_d;
    logic          w_valid_d, w_err_d;
    logic          w_fall;

    // Two-flop synchronisers; lines idle high.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
        end
    end

    // Glitch filters: accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_clk_filt  <= 1'b1;
            r_data_filt <= 1'b1;
            r_clk_cnt   <= '0;
            r_data_cnt  <= '0;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_prev <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_clk_cnt <= '0;
            end else if (r_clk_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_clk_cnt  <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
            if (r_data_sync[1] == r_data_filt) begin
                r_data_cnt <= '0;
            end else if (r_data_cnt == FW'(FILTER_LEN - 1)) begin
                r_data_filt <= r_data_sync[1];
                r_data_cnt  <= '0;
            end else begin
                r_data_cnt <= r_data_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_filt;

    // Byte FSM next-state, shift register, parity check and bit timeout.
    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        w_par_d   = r_par;
        w_valid_d = 1'b0;
        w_err_d   = 1'b0;
        w_timer_d = (w_fall || r_state == ST_IDLE) ? '0 : r_timer + 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_fall && !r_data_filt) begin
                    w_state_d = ST_DATA;
                    w_cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (w_fall) begin
                    w_shift_d = {r_data_filt, r_shift[7:1]};
                    if (r_cnt == CW'(DATA_BITS - 1)) w_state_d = ST_PARITY;
                    else                             w_cnt_d   = r_cnt + 1'b1;
                end
            end
            ST_PARITY: begin
                if (w_fall) begin
                    w_par_d   = r_data_filt;
                    w_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_d = ST_IDLE;
                    if ((^{r_shift, r_par}) && r_data_filt) w_valid_d = 1'b1;
                    else                                     w_err_d   = 1'b1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Stalled frame: abort back to IDLE with an error.
        if (r_state != ST_IDLE && !w_fall && r_timer == TW'(BIT_TIMEOUT - 1)) begin
            w_state_d = ST_IDLE;
            w_err_d   = 1'b1;
        end
    end

    // Byte FSM state and output registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_timer <= '0;
            o_byte  <= '0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_cnt   <= w_cnt_d;
            r_par   <= w_par_d;
            r_timer <= w_timer_d;
            o_valid <= w_valid_d;
            o_err   <= w_err_d;
            if (w_valid_d) o_byte <= r_shift;
        end
    end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: assembles validated bytes into complete scan-code sequences on ps2_key.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned BIT_TIMEOUT = 12000,
    parameter int unsigned SEQ_TIMEOUT = 24000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [64:0] ps2_key,
    output logic        rx_err
);

    localparam int unsigned SW = $clog2(SEQ_TIMEOUT + 1);

    logic [7:0]    w_byte;
    logic          w_valid, w_err;
    logic [55:0]   r_seq;
    logic [3:0]    r_n, w_n_inc;
    logic [2:0]    r_e1_left, w_e1_next;
    logic [SW-1:0] r_seq_timer;
    logic [63:0]   w_seq_new;
    logic          w_prev_e0, w_close;

    ps2_byte_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .BIT_TIMEOUT (BIT_TIMEOUT)
    ) u_byte_rx (
        .clk        (clk_sys),
        .i_rst      (reset),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_byte     (w_byte),
        .o_valid    (w_valid),
        .o_err      (w_err)
    );

    assign rx_err = w_err;

    // Decide whether the incoming byte extends the open sequence or closes it.
    always_comb begin
        w_n_inc   = (r_n == 4'd8) ? 4'd8 : r_n + 4'd1;
        w_seq_new = {r_seq, w_byte};
        w_prev_e0 = (r_n != 4'd0) && (r_seq[7:0] == PS2_E0);
        w_e1_next = 3'd0;
        w_close   = 1'b1;
        if (r_e1_left != 3'd0) begin
            w_e1_next = r_e1_left - 3'd1;
            w_close   = (r_e1_left == 3'd1);
        end else if (w_byte == PS2_E1) begin
            w_e1_next = 3'd7;
            w_close   = 1'b0;
        end else if (w_byte == PS2_E0 || w_byte == PS2_F0) begin
            w_close = 1'b0;
        end else if ((w_byte == PS2_FAKE_LSHIFT || w_byte == PS2_FAKE_NUMLK) && w_prev_e0) begin
            w_close = 1'b0;
        end
    end

    // Sequence buffer, sequence timer and ps2_key output register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ps2_key     <= '0;
            r_seq       <= '0;
            r_n         <= '0;
            r_e1_left   <= '0;
            r_seq_timer <= '0;
        end else if (w_err) begin
            r_seq       <= '0;
            r_n         <= '0;
            r_e1_left   <= '0;
            r_seq_timer <= '0;
        end else if (w_valid) begin
            r_seq_timer <= '0;
            if (w_close) begin
                ps2_key   <= {~ps2_key[64], w_seq_new & seq_keep_mask(w_n_inc)};
                r_seq     <= '0;
                r_n       <= '0;
                r_e1_left <= '0;
            end else begin
                r_seq     <= w_seq_new[55:0];
                r_n       <= w_n_inc;
                r_e1_left <= w_e1_next;
            end
        end else if (r_n != 4'd0) begin
            if (r_seq_timer == SW'(SEQ_TIMEOUT - 1)) begin
                r_seq       <= '0;
                r_n         <= '0;
                r_e1_left   <= '0;
                r_seq_timer <= '0;
            end else begin
                r_seq_timer <= r_seq_timer + 1'b1;
            end
        end
    end

endmodule
